// File: rtl/icache_ctrl.sv
// Direct-mapped read-only instruction cache: single-cycle hits, one 128-bit
// block refill per miss through the MEM_READ/MEM_BUSYWAIT handshake.
module icache_ctrl #(
  parameter int INDEX_BITS = 3,
  parameter int TAG_BITS   = 28 - INDEX_BITS
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         READ_EN,
  input  logic [31:0]  PC,
  output logic [31:0]  INSTRUCTION,
  output logic         BUSYWAIT,
  output logic         MEM_READ,
  output logic [27:0]  MEM_ADDRESS,
  input  logic [127:0] MEM_READDATA,
  input  logic         MEM_BUSYWAIT
);

  localparam int SETS = 1 << INDEX_BITS;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MEM_READ,
    S_UPDATE
  } state_t;

  state_t                state_reg, state_next;
  logic [27:0]           miss_addr_reg;
  logic [127:0]          fill_data_reg;
  logic [31:0]           instr_reg;
  logic [SETS-1:0]       valid_reg;
  logic [SETS-1:0]       set_wr;
  logic [TAG_BITS-1:0]   tag_mem  [SETS];
  logic [127:0]          data_mem [SETS];

  logic [INDEX_BITS-1:0] pc_index;
  logic [TAG_BITS-1:0]   pc_tag;
  logic [1:0]            pc_offset;
  logic [INDEX_BITS-1:0] fill_index;
  logic [TAG_BITS-1:0]   fill_tag;
  logic [127:0]          hit_line;
  logic [31:0]           hit_word;
  logic                  hit;
  logic                  miss;
  logic                  unused_pc_bits;

  assign pc_offset      = PC[3:2];
  assign pc_index       = PC[3+INDEX_BITS:4];
  assign pc_tag         = PC[31:4+INDEX_BITS];
  assign fill_index     = miss_addr_reg[INDEX_BITS-1:0];
  assign fill_tag       = miss_addr_reg[27:INDEX_BITS];
  assign unused_pc_bits = ^PC[1:0];

  assign hit_line = data_mem[pc_index];
  assign hit      = (state_reg == S_IDLE) && READ_EN && valid_reg[pc_index]
                    && (tag_mem[pc_index] == pc_tag);
  assign miss     = (state_reg == S_IDLE) && READ_EN && !hit;

  always_comb begin
    hit_word = hit_line[31:0];
    case (pc_offset)
      2'd1:    hit_word = hit_line[63:32];
      2'd2:    hit_word = hit_line[95:64];
      2'd3:    hit_word = hit_line[127:96];
      default: hit_word = hit_line[31:0];
    endcase
  end

  // One write strobe per set, raised only while the captured block is written back.
  for (genvar gi = 0; gi < SETS; gi++) begin : g_set_wr
    assign set_wr[gi] = (state_reg == S_UPDATE) && (fill_index == INDEX_BITS'(gi));
  end

  always_comb begin
    state_next = state_reg;
    BUSYWAIT   = 1'b0;
    MEM_READ   = 1'b0;
    case (state_reg)
      S_IDLE: begin
        // Gated by RESET so the stall drops the instant reset is asserted.
        BUSYWAIT = miss && RESET;
        if (miss) state_next = S_MEM_READ;
      end
      S_MEM_READ: begin
        BUSYWAIT = 1'b1;
        MEM_READ = 1'b1;
        if (!MEM_BUSYWAIT) state_next = S_UPDATE;
      end
      S_UPDATE: begin
        BUSYWAIT   = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign MEM_ADDRESS = miss_addr_reg;
  assign INSTRUCTION = hit ? hit_word : instr_reg;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_reg     <= S_IDLE;
      miss_addr_reg <= '0;
      instr_reg     <= '0;
      valid_reg     <= '0;
    end else begin
      state_reg <= state_next;
      valid_reg <= valid_reg | set_wr;
      if (miss) miss_addr_reg <= PC[31:4];
      if (hit)  instr_reg     <= hit_word;
    end
  end

  // Tag/data storage carries no reset; the valid bits alone qualify it.
  always_ff @(posedge CLK) begin
    if ((state_reg == S_MEM_READ) && !MEM_BUSYWAIT) fill_data_reg <= MEM_READDATA;
    if (state_reg == S_UPDATE) begin
      tag_mem[fill_index]  <= fill_tag;
      data_mem[fill_index] <= fill_data_reg;
    end
  end

endmodule

// File: tb/tb_icache_ctrl.sv
// Bench for icache_ctrl: directed vector table, multi-cycle corner sequences
// and random accesses checked against a set/tag/valid reference model.
module tb_icache_ctrl;

  logic         CLK;
  logic         RESET;
  logic         READ_EN;
  logic [31:0]  PC;
  logic [31:0]  INSTRUCTION;
  logic         BUSYWAIT;
  logic         MEM_READ;
  logic [27:0]  MEM_ADDRESS;
  logic [127:0] MEM_READDATA;
  logic         MEM_BUSYWAIT;

  int total = 0;
  int bad   = 0;
  int mem_lat = 1;
  int mem_cnt = 0;

  typedef struct {
    logic        re;
    logic [31:0] pc;
    int          lat;
    int          exp_stall;
    int          exp_mcyc;
    logic [27:0] exp_addr;
    logic [31:0] exp_instr;
  } vec_t;

  vec_t vecs[10];

  bit          m_valid [8];
  logic [24:0] m_tag   [8];
  logic [31:0] m_last;

  icache_ctrl dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .READ_EN      (READ_EN),
    .PC           (PC),
    .INSTRUCTION  (INSTRUCTION),
    .BUSYWAIT     (BUSYWAIT),
    .MEM_READ     (MEM_READ),
    .MEM_ADDRESS  (MEM_ADDRESS),
    .MEM_READDATA (MEM_READDATA),
    .MEM_BUSYWAIT (MEM_BUSYWAIT)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  function automatic logic [127:0] mem_block(input logic [27:0] a);
    logic [127:0] b;
    if (a == 28'h0) return 128'h33221100_77665544_BBAA9988_FFEEDDCC;
    for (int i = 0; i < 4; i++) b[i*32 +: 32] = ({a, 4'(i)} * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    return b;
  endfunction

  function automatic logic [31:0] word_of(input logic [27:0] blk, input int off);
    logic [127:0] b;
    b = mem_block(blk);
    return b[off*32 +: 32];
  endfunction

  // Memory: data valid in the lat-th cycle of a MEM_READ request, junk before.
  initial begin
    MEM_BUSYWAIT = 1'b1;
    MEM_READDATA = '0;
    forever begin
      @(negedge CLK);
      if (MEM_READ) begin
        mem_cnt++;
        MEM_BUSYWAIT = (mem_cnt < mem_lat);
        MEM_READDATA = MEM_BUSYWAIT ? {$urandom, $urandom, $urandom, $urandom}
                                    : mem_block(MEM_ADDRESS);
      end else begin
        mem_cnt      = 0;
        MEM_BUSYWAIT = 1'b1;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Starts one fetch at posedge+1 and waits (bounded) until BUSYWAIT is low.
  task automatic do_access(input logic re, input logic [31:0] pc, input int lat,
                           input bit sw, input logic [31:0] sw_pc,
                           output logic [31:0] instr, output int stalls, output int mcyc,
                           output logic [27:0] a_first, output logic [27:0] a_last,
                           output bit to);
    bit done;
    done = 0; to = 1; instr = '0; stalls = 0; mcyc = 0; a_first = '0; a_last = '0;
    READ_EN = re; PC = pc; mem_lat = lat;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge CLK);
      if (MEM_READ) begin
        if (mcyc == 0) begin
          a_first = MEM_ADDRESS;
          if (sw) PC = sw_pc;
        end
        a_last = MEM_ADDRESS;
        mcyc++;
      end
      if (!BUSYWAIT) begin
        instr = INSTRUCTION;
        done  = 1;
        to    = 0;
      end else begin
        stalls++;
      end
      @(posedge CLK);
      #1;
    end
    if (to) begin
      total++;
      bad++;
      $display("FAIL timeout: pc=%h still stalled after 200 cycles, want BUSYWAIT=0", pc);
    end
  endtask

  task automatic run_vec(input string name, input vec_t v);
    logic [31:0] instr;
    logic [27:0] af, al;
    int st, mc;
    bit to;
    do_access(v.re, v.pc, v.lat, 1'b0, 32'h0, instr, st, mc, af, al, to);
    $display("txn %s re=%0b pc=%h stall=%0d memcyc=%0d addr=%h instr=%h",
             name, v.re, v.pc, st, mc, af, instr);
    if (!to) begin
      check({name, ".stall"}, 32'(st), 32'(v.exp_stall));
      check({name, ".memcyc"}, 32'(mc), 32'(v.exp_mcyc));
      check({name, ".instr"}, instr, v.exp_instr);
      if (v.exp_mcyc > 0) begin
        check({name, ".addr_first"}, 32'(af), 32'(v.exp_addr));
        check({name, ".addr_last"}, 32'(al), 32'(v.exp_addr));
      end
    end
  endtask

  task automatic pulse_reset();
    READ_EN = 1'b0;
    @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);
    RESET = 1'b1;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    logic [31:0] instr;
    logic [27:0] af, al, blk;
    int st, mc, off;
    bit to, seen;
    vec_t v;

    RESET = 1'b1; READ_EN = 1'b1; PC = 32'h0;
    #2 RESET = 1'b0;
    #1;
    check("reset.busywait", 32'(BUSYWAIT), 32'h0);
    check("reset.mem_read", 32'(MEM_READ), 32'h0);
    check("reset.instr", INSTRUCTION, 32'h0);
    check("reset.mem_addr", 32'(MEM_ADDRESS), 32'h0);
    READ_EN = 1'b0;
    @(negedge CLK);
    RESET = 1'b1;
    @(posedge CLK);
    #1;

    vecs[0] = '{1'b1, 32'h00000000, 15, 17, 15, 28'h0, 32'hFFEEDDCC};
    vecs[1] = '{1'b1, 32'h00000004,  1,  0,  0, 28'h0, 32'hBBAA9988};
    vecs[2] = '{1'b1, 32'h00000008,  1,  0,  0, 28'h0, 32'h77665544};
    vecs[3] = '{1'b1, 32'h0000000C,  1,  0,  0, 28'h0, 32'h33221100};
    vecs[4] = '{1'b0, 32'h12345678,  1,  0,  0, 28'h0, 32'h33221100};
    vecs[5] = '{1'b1, 32'h00000080,  3,  5,  3, 28'h8, word_of(28'h8, 0)};
    vecs[6] = '{1'b1, 32'h00000000,  1,  3,  1, 28'h0, 32'hFFEEDDCC};
    vecs[7] = '{1'b1, 32'h00000084,  2,  4,  2, 28'h8, word_of(28'h8, 1)};
    vecs[8] = '{1'b1, 32'h00000004,  4,  6,  4, 28'h0, 32'hBBAA9988};
    vecs[9] = '{1'b1, 32'h00000004,  1,  0,  0, 28'h0, 32'hBBAA9988};
    for (int i = 0; i < 10; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

    // PC moves from 0x10 to 0x20 once the fill is under way.
    do_access(1'b1, 32'h10, 5, 1'b1, 32'h20, instr, st, mc, af, al, to);
    $display("txn pcswitch stall=%0d memcyc=%0d first=%h last=%h instr=%h", st, mc, af, al, instr);
    if (!to) begin
      check("pcswitch.addr_first", 32'(af), 32'h1);
      check("pcswitch.addr_last", 32'(al), 32'h2);
      check("pcswitch.memcyc", 32'(mc), 32'd10);
      check("pcswitch.stall", 32'(st), 32'd14);
      check("pcswitch.instr", instr, word_of(28'h2, 0));
    end
    v = '{1'b1, 32'h10, 1, 0, 0, 28'h0, word_of(28'h1, 0)};
    run_vec("pcswitch_hit", v);

    // Reset asserted in the middle of a fill.
    READ_EN = 1'b1; PC = 32'h30; mem_lat = 10;
    seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge CLK);
      if (MEM_READ) seen = 1;
    end
    check("midreset.reached_mem_read", 32'(seen), 32'h1);
    #2 RESET = 1'b0;
    #1;
    $display("txn midreset busywait=%0b mem_read=%0b instr=%h", BUSYWAIT, MEM_READ, INSTRUCTION);
    check("midreset.mem_read", 32'(MEM_READ), 32'h0);
    check("midreset.busywait", 32'(BUSYWAIT), 32'h0);
    check("midreset.instr", INSTRUCTION, 32'h0);
    check("midreset.mem_addr", 32'(MEM_ADDRESS), 32'h0);
    READ_EN = 1'b0;
    @(negedge CLK);
    RESET = 1'b1;
    @(posedge CLK);
    #1;
    v = '{1'b1, 32'h4, 2, 4, 2, 28'h0, 32'hBBAA9988};
    run_vec("after_reset", v);

    // Random accesses against a set/tag/valid model.
    pulse_reset();
    for (int s = 0; s < 8; s++) m_valid[s] = 0;
    m_last = 32'h0;
    for (int i = 0; i < 60; i++) begin
      v.re  = ($urandom_range(0, 3) != 0);
      v.lat = $urandom_range(1, 6);
      blk   = 28'($urandom_range(0, 31));
      off   = $urandom_range(0, 3);
      v.pc  = {blk, 2'(off), 2'($urandom_range(0, 3))};
      v.exp_stall = 0; v.exp_mcyc = 0; v.exp_addr = blk;
      if (!v.re) begin
        v.pc = $urandom;
        v.exp_instr = m_last;
      end else begin
        if (!(m_valid[blk[2:0]] && m_tag[blk[2:0]] == blk[27:3])) begin
          v.exp_stall = v.lat + 2;
          v.exp_mcyc  = v.lat;
          m_valid[blk[2:0]] = 1;
          m_tag[blk[2:0]]   = blk[27:3];
        end
        v.exp_instr = word_of(blk, off);
        m_last = v.exp_instr;
      end
      run_vec($sformatf("rnd%0d", i), v);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
